branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 217 +++++++++++++++++++++
 tb/tb_branch_resolve.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve: dual-lane branch/JAL resolution, predictor update, fetch   |
// | redirect on mispredict and branch/mispredict performance counters.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

package branch_resolve_pkg;
  typedef struct packed {
    logic [1:0]  is_branch;
    logic [1:0]  is_jal;
    logic [1:0]  taken;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [31:0] target0;
    logic [31:0] target1;
  } ex_bp_info_t;
endpackage

module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter bit CntSat = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [1:0]  ex_valid_i,
  input  logic [1:0]  ex_is_branch_i,
  input  logic [1:0]  ex_is_jal_i,
  input  logic [1:0]  ex_is_comp_i,
  input  logic [31:0] ex_pc0_i,
  input  logic [31:0] ex_pc1_i,
  input  logic [1:0]  ex_ptaken_i,
  input  logic [31:0] ex_ptarget0_i,
  input  logic [31:0] ex_ptarget1_i,
  input  logic [1:0]  ex_taken_i,
  input  logic [31:0] ex_target0_i,
  input  logic [31:0] ex_target1_i,
  input  logic        bp_init_req_i,
  input  logic        cnt_clr_i,
  output ex_bp_info_t ex_bp_info_o,
  output logic        ex_bp_init_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        squash_lane1_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int unsigned LANES   = 2;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  logic [LANES-1:0][31:0] pc;
  logic [LANES-1:0][31:0] ptgt;
  logic [LANES-1:0][31:0] tgt;
  logic [LANES-1:0][31:0] act_tgt;
  logic [LANES-1:0]       ctl;
  logic [LANES-1:0]       mp_raw;
  logic [LANES-1:0]       act_taken;
  logic [LANES-1:0]       resolve;
  logic [LANES-1:0]       mispred;
  logic                   mp0;
  logic                   res1;
  logic                   mp1;

  assign pc   = {ex_pc1_i, ex_pc0_i};
  assign ptgt = {ex_ptarget1_i, ex_ptarget0_i};
  assign tgt  = {ex_target1_i, ex_target0_i};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [31:0] fallthru;
    logic        tgt_diff;

    assign fallthru     = pc[i] + (ex_is_comp_i[i] ? 32'd2 : 32'd4);
    assign tgt_diff     = (tgt[i] != ptgt[i]);
    // A JAL is always taken regardless of what the execute stage reported.
    assign act_taken[i] = ex_is_jal_i[i] | ex_taken_i[i];
    assign act_tgt[i]   = act_taken[i] ? tgt[i] : fallthru;
    assign ctl[i]       = ex_valid_i[i] & (ex_is_branch_i[i] | ex_is_jal_i[i]);
    assign mp_raw[i]    = ex_is_jal_i[i]
                        ? (~ex_ptaken_i[i] | tgt_diff)
                        : ((ex_taken_i[i] ^ ex_ptaken_i[i]) | (ex_taken_i[i] & tgt_diff));
  end

  // Lane 1 only counts when the older lane did not redirect the stream.
  assign mp0     = ctl[0] & mp_raw[0];
  assign res1    = ctl[1] & ~mp0;
  assign mp1     = res1 & mp_raw[1];
  assign resolve = {res1, ctl[0]};
  assign mispred = {mp1, mp0};

  function automatic logic [31:0] cnt_next(input logic [31:0] cur, input logic [1:0] inc);
    logic [32:0] sum;
    sum = {1'b0, cur} + {31'd0, inc};
    if (CntSat && sum[32]) begin
      return CNT_MAX;
    end
    return sum[31:0];
  endfunction

  state_e state_q;
  state_e state_d;
  logic   bp_init_q;
  logic   bp_init_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // INIT entered from reset still owes its strobe; INIT entered from RUN has
  // already emitted it on the way in.
  always_comb begin
    state_d   = state_q;
    bp_init_d = 1'b0;
    case (state_q)
      INIT: begin
        bp_init_d = ~bp_init_q | bp_init_req_i;
        state_d   = RUN;
      end
      RUN: begin
        if (bp_init_req_i) begin
          bp_init_d = 1'b1;
          state_d   = INIT;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  ex_bp_info_t info_q;
  ex_bp_info_t info_d;
  logic        redirect_q;
  logic        redirect_d;
  logic [31:0] redirect_pc_q;
  logic [31:0] redirect_pc_d;
  logic        squash_q;
  logic        squash_d;
  logic [31:0] branch_cnt_q;
  logic [31:0] branch_cnt_d;
  logic [31:0] mispred_cnt_q;
  logic [31:0] mispred_cnt_d;
  logic [1:0]  br_inc;
  logic [1:0]  mp_inc;

  assign br_inc = {1'b0, resolve[0]} + {1'b0, resolve[1]};
  assign mp_inc = {1'b0, |mispred};

  always_comb begin
    info_d           = '0;
    info_d.is_branch = ex_is_branch_i & resolve & {LANES{~bp_init_d}};
    info_d.is_jal    = ex_is_jal_i & resolve & {LANES{~bp_init_d}};
    info_d.taken     = act_taken;
    info_d.pc0       = ex_pc0_i;
    info_d.pc1       = ex_pc1_i;
    info_d.target0   = act_tgt[0];
    info_d.target1   = act_tgt[1];

    redirect_d    = |mispred;
    redirect_pc_d = redirect_pc_q;
    if (mispred[0]) begin
      redirect_pc_d = act_tgt[0];
    end else if (mispred[1]) begin
      redirect_pc_d = act_tgt[1];
    end
    squash_d = mispred[0] & ex_valid_i[1];

    if (cnt_clr_i) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      branch_cnt_d  = cnt_next(branch_cnt_q, br_inc);
      mispred_cnt_d = cnt_next(mispred_cnt_q, mp_inc);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      info_q        <= '0;
      bp_init_q     <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      squash_q      <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      info_q        <= info_d;
      bp_init_q     <= bp_init_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      squash_q      <= squash_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign ex_bp_info_o   = info_q;
  assign ex_bp_init_o   = bp_init_q;
  assign redirect_o     = redirect_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign squash_lane1_o = squash_q;
  assign branch_cnt_o   = branch_cnt_q;
  assign mispred_cnt_o  = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_resolve: directed and random checks of branch_resolve.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam bit CNT_SAT = 1'b1;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  ex_valid_i, ex_is_branch_i, ex_is_jal_i, ex_is_comp_i;
  logic [31:0] ex_pc0_i, ex_pc1_i;
  logic [1:0]  ex_ptaken_i;
  logic [31:0] ex_ptarget0_i, ex_ptarget1_i;
  logic [1:0]  ex_taken_i;
  logic [31:0] ex_target0_i, ex_target1_i;
  logic        bp_init_req_i, cnt_clr_i;
  ex_bp_info_t ex_bp_info_o;
  logic        ex_bp_init_o, redirect_o, squash_lane1_o;
  logic [31:0] redirect_pc_o, branch_cnt_o, mispred_cnt_o;

  branch_resolve #(.CntSat(CNT_SAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .ex_is_branch_i(ex_is_branch_i), .ex_is_jal_i(ex_is_jal_i),
    .ex_is_comp_i(ex_is_comp_i), .ex_pc0_i(ex_pc0_i), .ex_pc1_i(ex_pc1_i),
    .ex_ptaken_i(ex_ptaken_i), .ex_ptarget0_i(ex_ptarget0_i), .ex_ptarget1_i(ex_ptarget1_i),
    .ex_taken_i(ex_taken_i), .ex_target0_i(ex_target0_i), .ex_target1_i(ex_target1_i),
    .bp_init_req_i(bp_init_req_i), .cnt_clr_i(cnt_clr_i),
    .ex_bp_info_o(ex_bp_info_o), .ex_bp_init_o(ex_bp_init_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .squash_lane1_o(squash_lane1_o),
    .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  longint unsigned exp_b = 0;
  longint unsigned exp_m = 0;
  bit init_owed = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ex_valid_i = '0; ex_is_branch_i = '0; ex_is_jal_i = '0; ex_is_comp_i = '0;
    ex_pc0_i = '0; ex_pc1_i = '0; ex_ptaken_i = '0; ex_ptarget0_i = '0; ex_ptarget1_i = '0;
    ex_taken_i = '0; ex_target0_i = '0; ex_target1_i = '0;
    bp_init_req_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  task automatic set_lane(input int l, input bit v, input bit br, input bit jal, input bit comp,
                          input logic [31:0] pc, input bit pt, input logic [31:0] ptg,
                          input bit t, input logic [31:0] tg);
    ex_valid_i[l] = v; ex_is_branch_i[l] = br; ex_is_jal_i[l] = jal; ex_is_comp_i[l] = comp;
    ex_ptaken_i[l] = pt; ex_taken_i[l] = t;
    if (l == 0) begin
      ex_pc0_i = pc; ex_ptarget0_i = ptg; ex_target0_i = tg;
    end else begin
      ex_pc1_i = pc; ex_ptarget1_i = ptg; ex_target1_i = tg;
    end
  endtask

  // Reference: evaluate the resolution rules for the current inputs, advance
  // one clock and compare every registered output.
  task automatic step();
    logic [31:0] pcs [2];
    logic [31:0] tgs [2];
    logic [31:0] ptgs [2];
    logic [31:0] actual [2];
    bit [1:0] res, mp, tk, br_bits, jal_bits;
    bit init, rd, sq;
    logic [31:0] rpc;
    longint unsigned nb, nm;
    pcs[0] = ex_pc0_i; pcs[1] = ex_pc1_i;
    tgs[0] = ex_target0_i; tgs[1] = ex_target1_i;
    ptgs[0] = ex_ptarget0_i; ptgs[1] = ex_ptarget1_i;
    res = '0; mp = '0;
    for (int i = 0; i < 2; i++) begin
      bit is_ctl, wrong;
      is_ctl = ex_valid_i[i] && (ex_is_branch_i[i] || ex_is_jal_i[i]);
      tk[i] = ex_is_jal_i[i] ? 1'b1 : ex_taken_i[i];
      actual[i] = tk[i] ? tgs[i] : pcs[i] + (ex_is_comp_i[i] ? 32'd2 : 32'd4);
      if (ex_is_jal_i[i])
        wrong = !ex_ptaken_i[i] || (tgs[i] != ptgs[i]);
      else
        wrong = (ex_taken_i[i] != ex_ptaken_i[i]) ||
                (ex_taken_i[i] && ex_ptaken_i[i] && tgs[i] != ptgs[i]);
      res[i] = is_ctl && !(i == 1 && mp[0]);
      mp[i] = res[i] && wrong;
    end
    init = init_owed || bp_init_req_i;
    init_owed = 1'b0;
    br_bits = init ? 2'b00 : (res & ex_is_branch_i);
    jal_bits = init ? 2'b00 : (res & ex_is_jal_i);
    rd = (mp != 0);
    rpc = mp[0] ? actual[0] : actual[1];
    sq = mp[0] && ex_valid_i[1];
    nb = exp_b + res[0] + res[1];
    nm = exp_m + (rd ? 1 : 0);
    if (nb > 64'hFFFF_FFFF) nb = CNT_SAT ? 64'hFFFF_FFFF : nb - 64'h1_0000_0000;
    if (nm > 64'hFFFF_FFFF) nm = CNT_SAT ? 64'hFFFF_FFFF : nm - 64'h1_0000_0000;
    if (cnt_clr_i) begin nb = 0; nm = 0; end
    exp_b = nb; exp_m = nm;

    @(posedge clk_i); #1;
    chk("bp_init", {63'd0, ex_bp_init_o}, {63'd0, init});
    chk("is_branch", {62'd0, ex_bp_info_o.is_branch}, {62'd0, br_bits});
    chk("is_jal", {62'd0, ex_bp_info_o.is_jal}, {62'd0, jal_bits});
    chk("taken", {62'd0, ex_bp_info_o.taken}, {62'd0, tk});
    chk("pc0", {32'd0, ex_bp_info_o.pc0}, {32'd0, pcs[0]});
    chk("pc1", {32'd0, ex_bp_info_o.pc1}, {32'd0, pcs[1]});
    chk("target0", {32'd0, ex_bp_info_o.target0}, {32'd0, actual[0]});
    chk("target1", {32'd0, ex_bp_info_o.target1}, {32'd0, actual[1]});
    chk("redirect", {63'd0, redirect_o}, {63'd0, rd});
    if (rd) chk("redirect_pc", {32'd0, redirect_pc_o}, {32'd0, rpc});
    chk("squash", {63'd0, squash_lane1_o}, {63'd0, sq});
    chk("branch_cnt", {32'd0, branch_cnt_o}, exp_b);
    chk("mispred_cnt", {32'd0, mispred_cnt_o}, exp_m);
  endtask

  task automatic preload(input logic [31:0] b, input logic [31:0] m);
    force dut.branch_cnt_q = b;
    force dut.mispred_cnt_q = m;
    #1;
    release dut.branch_cnt_q;
    release dut.mispred_cnt_q;
    exp_b = b; exp_m = m;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_info"}, {63'd0, ex_bp_info_o === '0}, 64'd1);
    chk({tag, "_init"}, {63'd0, ex_bp_init_o}, 64'd0);
    chk({tag, "_redirect"}, {63'd0, redirect_o}, 64'd0);
    chk({tag, "_rpc"}, {32'd0, redirect_pc_o}, 64'd0);
    chk({tag, "_squash"}, {63'd0, squash_lane1_o}, 64'd0);
    chk({tag, "_bcnt"}, {32'd0, branch_cnt_o}, 64'd0);
    chk({tag, "_mcnt"}, {32'd0, mispred_cnt_o}, 64'd0);
  endtask

  initial begin
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_state("rst");
    rst_ni = 1'b1;
    init_owed = 1'b1; exp_b = 0; exp_m = 0;
    step();
    step();

    // Lane-0 taken branch predicted not-taken
    set_lane(0, 1, 1, 0, 0, 32'h100, 0, 32'h0, 1, 32'h180);
    step();

    // Compressed lane-0 mispredict squashes a valid lane-1 JAL
    set_lane(0, 1, 1, 0, 1, 32'h200, 1, 32'h300, 0, 32'h300);
    set_lane(1, 1, 0, 1, 0, 32'h202, 1, 32'h400, 1, 32'h400);
    step();

    // Both lanes correctly predicted
    set_lane(0, 1, 1, 0, 0, 32'h300, 0, 32'h0, 0, 32'h380);
    set_lane(1, 1, 0, 1, 0, 32'h304, 1, 32'h500, 1, 32'h500);
    step();

    // Saturation from FFFF_FFFE and at FFFF_FFFF, then clear beating increment
    preload(32'hFFFF_FFFE, 32'hFFFF_FFFF);
    step();
    step();
    set_lane(0, 1, 1, 0, 0, 32'h600, 0, 32'h0, 1, 32'h700);
    step();
    clear_inputs();
    set_lane(0, 1, 1, 0, 0, 32'h300, 0, 32'h0, 0, 32'h380);
    set_lane(1, 1, 0, 1, 0, 32'h304, 1, 32'h500, 1, 32'h500);
    preload(32'hFFFF_FFFE, 32'h5);
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;

    // Init request alongside a resolving branch
    clear_inputs();
    set_lane(0, 1, 1, 0, 0, 32'h800, 0, 32'h0, 0, 32'h900);
    bp_init_req_i = 1'b1;
    step();
    bp_init_req_i = 1'b0;
    step();

    // Reset in the middle of a mispredict cycle
    set_lane(0, 1, 1, 0, 0, 32'hA00, 0, 32'h0, 1, 32'hB00);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_reset_state("midrst");
    clear_inputs();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    init_owed = 1'b1; exp_b = 0; exp_m = 0;
    step();

    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      for (int l = 0; l < 2; l++) begin
        int kind;
        logic [31:0] tg;
        kind = int'($urandom_range(0, 2));
        tg = $urandom & 32'hFFFF_FFFE;
        set_lane(l, ($urandom % 4) != 0, kind == 1, kind == 2, $urandom % 2,
                 $urandom & 32'hFFFF_FFFE, $urandom % 2,
                 ($urandom % 2) ? tg : ($urandom & 32'hFFFF_FFFE), $urandom % 2, tg);
      end
      bp_init_req_i = ($urandom % 16) == 0;
      cnt_clr_i = ($urandom % 32) == 0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
